// File: rtl/mdio_pkg.sv
// Shared frame constants, FSM state type and per-field length helpers for the MDIO master.
package mdio_pkg;

    localparam logic [1:0] OpRd      = 2'b10;
    localparam logic [1:0] OpWr      = 2'b01;
    localparam logic [1:0] StartBits = 2'b01;
    localparam logic [1:0] TaWr      = 2'b10;

    localparam int unsigned AddrLen = 5;
    localparam int unsigned DataLen = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StStart,
        StOp,
        StPhy,
        StReg,
        StTa,
        StData
    } mdio_state_e;

    // Bit-count terminal (length - 1) of each fixed-length field.
    function automatic logic [4:0] field_last(mdio_state_e s);
        case (s)
            StPhy, StReg: return 5'(AddrLen - 1);
            StData:       return 5'(DataLen - 1);
            default:      return 5'd1;
        endcase
    endfunction

    function automatic mdio_state_e next_field(mdio_state_e s);
        case (s)
            StPre:   return StStart;
            StStart: return StOp;
            StOp:    return StPhy;
            StPhy:   return StReg;
            StReg:   return StTa;
            StTa:    return StData;
            default: return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/mdio_bit_timer.sv
// MDC generator: half-period counter producing mdc plus rise and bit-boundary strobes.
module mdio_bit_timer #(
    parameter int unsigned DivHalf = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic mdc_o,
    output logic rise_o,
    output logic bound_o
);

    localparam int unsigned CntW = $clog2(DivHalf);
    localparam logic [CntW-1:0] CntLast = CntW'(DivHalf - 1);

    logic [CntW-1:0] cnt_q;
    logic            phase_q;
    logic            wrap;

    assign wrap = run_i && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!run_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // rise: the next edge takes mdc high; bound: the next edge starts a new bit.
    assign mdc_o   = phase_q;
    assign rise_o  = wrap && !phase_q;
    assign bound_o = wrap && phase_q;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read or write frame per accepted request onto MDC/MDIO.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned DivHalf     = 20,
    parameter int unsigned PreambleLen = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        op_rd_i,
    input  logic [4:0]  phy_addr_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        rd_err_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    localparam logic [4:0] PreLast = (PreambleLen == 0) ? 5'd0 : 5'(PreambleLen - 1);
    localparam mdio_state_e FirstState = (PreambleLen == 0) ? StStart : StPre;

    mdio_state_e state_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] tx_sr_q, rx_sr_q, wdata_q, rdata_q;
    logic [4:0]  phy_q, reg_q;
    logic        op_rd_q, busy_q, done_q, rd_err_q, ta_err_q, mdio_o_q, mdio_oe_q;
    logic [1:0]  sync_q;
    logic        rise, bound;

    mdio_state_e load_state;
    logic [15:0] load_bits;
    logic        load_oe;
    logic [4:0]  load_last;

    mdio_bit_timer #(
        .DivHalf(DivHalf)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run_i  (busy_q),
        .mdc_o  (mdc_o),
        .rise_o (rise),
        .bound_o(bound)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], mdio_i};
    end

    // Next field, left-justified; released fields shift out 1s so mdio_o rests high.
    always_comb begin
        load_state = (state_q == StIdle) ? FirstState : next_field(state_q);
        load_bits  = '1;
        load_oe    = 1'b1;
        load_last  = field_last(load_state);
        case (load_state)
            StPre:   load_last = PreLast;
            StStart: load_bits = {StartBits, 14'd0};
            StOp:    load_bits = {(op_rd_q ? OpRd : OpWr), 14'd0};
            StPhy:   load_bits = {phy_q, 11'd0};
            StReg:   load_bits = {reg_q, 11'd0};
            StTa: begin
                if (op_rd_q) load_oe = 1'b0;
                else         load_bits = {TaWr, 14'd0};
            end
            StData: begin
                if (op_rd_q) load_oe = 1'b0;
                else         load_bits = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_sr_q   <= '1;
            rx_sr_q   <= '0;
            op_rd_q   <= 1'b0;
            phy_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
            ta_err_q  <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (req_i) begin
                    op_rd_q   <= op_rd_i;
                    phy_q     <= phy_addr_i;
                    reg_q     <= reg_addr_i;
                    wdata_q   <= wdata_i;
                    busy_q    <= 1'b1;
                    ta_err_q  <= 1'b0;
                    state_q   <= load_state;
                    bit_cnt_q <= load_last;
                    mdio_o_q  <= load_bits[15];
                    mdio_oe_q <= load_oe;
                    tx_sr_q   <= {load_bits[14:0], 1'b1};
                end
            end else begin
                if (rise && op_rd_q) begin
                    if (state_q == StTa && bit_cnt_q == 5'd0) ta_err_q <= sync_q[1];
                    if (state_q == StData) rx_sr_q <= {rx_sr_q[14:0], sync_q[1]};
                end
                if (bound) begin
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_q <= bit_cnt_q - 5'd1;
                        mdio_o_q  <= tx_sr_q[15];
                        tx_sr_q   <= {tx_sr_q[14:0], 1'b1};
                    end else if (state_q == StData) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        mdio_o_q  <= 1'b1;
                        mdio_oe_q <= 1'b0;
                        rdata_q   <= op_rd_q ? rx_sr_q : rdata_q;
                        rd_err_q  <= op_rd_q & ta_err_q;
                    end else begin
                        state_q   <= load_state;
                        bit_cnt_q <= load_last;
                        mdio_o_q  <= load_bits[15];
                        mdio_oe_q <= load_oe;
                        tx_sr_q   <= {load_bits[14:0], 1'b1};
                    end
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign rd_err_o  = rd_err_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe_o = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench: default-parameter master with a PHY model, plus a fast no-preamble instance.
module tb_mdio_master;

    localparam int unsigned DivA = 20;
    localparam int unsigned PreA = 32;
    localparam int unsigned DivB = 2;
    localparam int unsigned PreB = 0;
    localparam int unsigned NA   = PreA + 32;
    localparam int unsigned NB   = PreB + 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_a = 1'b0, op_rd_a = 1'b0, mdi_a = 1'b1;
    logic [4:0]  phy_a = '0, reg_a = '0;
    logic [15:0] wdata_a = '0;
    logic        busy_a, done_a, rd_err_a, mdc_a, mdo_a, oe_a;
    logic [15:0] rdata_a;

    logic        req_b = 1'b0, op_rd_b = 1'b0, mdi_b = 1'b1;
    logic [4:0]  phy_b = '0, reg_b = '0;
    logic [15:0] wdata_b = '0;
    logic        busy_b, done_b, rd_err_b, mdc_b, mdo_b, oe_b;
    logic [15:0] rdata_b;

    mdio_master #(.DivHalf(DivA), .PreambleLen(PreA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .op_rd_i(op_rd_a), .phy_addr_i(phy_a),
        .reg_addr_i(reg_a), .wdata_i(wdata_a), .busy_o(busy_a), .done_o(done_a),
        .rdata_o(rdata_a), .rd_err_o(rd_err_a), .mdc_o(mdc_a), .mdio_o(mdo_a),
        .mdio_oe_o(oe_a), .mdio_i(mdi_a)
    );

    mdio_master #(.DivHalf(DivB), .PreambleLen(PreB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .op_rd_i(op_rd_b), .phy_addr_i(phy_b),
        .reg_addr_i(reg_b), .wdata_i(wdata_b), .busy_o(busy_b), .done_o(done_b),
        .rdata_o(rdata_b), .rd_err_o(rd_err_b), .mdc_o(mdc_b), .mdio_o(mdo_b),
        .mdio_oe_o(oe_b), .mdio_i(mdi_b)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [63:0] frame;
        logic [63:0] oe;
        int unsigned done_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model_rdata = 16'h0;
    logic        model_err   = 1'b0;
    logic        phy_resp    = 1'b0;
    logic [15:0] phy_rdata   = 16'h0;

    int unsigned rises_a = 0, rises_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    logic [63:0] fr_a = '0, oer_a = '0, fr_b = '0;
    logic        prev_mdc_a = 1'b0, prev_mdc_b = 1'b0, prev_mdo_b = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] low_mask(input int unsigned n);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    // Right-justified N-bit frame; released read bits are zero and masked out when compared.
    function automatic logic [63:0] exp_frame(input int unsigned pre, input logic rd,
                                              input logic [4:0] pa, input logic [4:0] ra,
                                              input logic [15:0] wd);
        logic [31:0] tail;
        logic [63:0] f;
        tail = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra, (rd ? 2'b00 : 2'b10), (rd ? 16'h0 : wd)};
        f = {32'h0, tail};
        for (int i = 0; i < int'(pre); i++) f[32+i] = 1'b1;
        return f;
    endfunction

    // PHY drive value for bit k; silent PHY leaves the pull-up.
    function automatic logic phy_bit(input int unsigned k);
        if (!phy_resp) return 1'b1;
        if (k == PreA + 15) return 1'b0;
        if (k >= PreA + 16 && k <= PreA + 31) return phy_rdata[PreA+31-k];
        return 1'b1;
    endfunction

    task automatic issue_a(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic resp, input logic [15:0] prd,
                           input bit push);
        exp_t e;
        op_rd_a = rd; phy_a = pa; reg_a = ra; wdata_a = wd; req_a = 1'b1;
        phy_resp = resp; phy_rdata = prd;
        if (push) begin
            if (rd) begin
                model_rdata = resp ? prd : 16'hFFFF;
                model_err   = ~resp;
            end else begin
                model_err = 1'b0;
            end
            e.rdata    = model_rdata;
            e.err      = model_err;
            e.oe       = rd ? (low_mask(NA) & ~low_mask(18)) : low_mask(NA);
            e.frame    = exp_frame(PreA, rd, pa, ra, wd);
            e.done_cyc = cyc + 1 + NA * 2 * DivA;
            q_a.push_back(e);
        end
        @(negedge clk);
        req_a = 1'b0;
    endtask

    task automatic issue_b(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        exp_t e;
        op_rd_b = 1'b0; phy_b = pa; reg_b = ra; wdata_b = wd; req_b = 1'b1;
        e.rdata    = 16'h0;
        e.err      = 1'b0;
        e.oe       = low_mask(NB);
        e.frame    = exp_frame(PreB, 1'b0, pa, ra, wd);
        e.done_cyc = cyc + 1 + NB * 2 * DivB;
        q_b.push_back(e);
        @(negedge clk);
        req_b = 1'b0;
    endtask

    task automatic wait_done_a(input int unsigned start);
        for (int i = 0; i < 4000 && done_cnt_a == start; i++) @(negedge clk);
        check_eq("a_done_seen", 64'(done_cnt_a), 64'(start + 1));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rises_a = 0; fr_a = '0; oer_a = '0; mdi_a = 1'b1; prev_mdc_a = 1'b0;
        end else begin
            if (mdc_a && !prev_mdc_a) begin
                fr_a  = {fr_a[62:0], mdo_a};
                oer_a = {oer_a[62:0], oe_a};
                rises_a++;
            end
            if (!mdc_a && prev_mdc_a) mdi_a = phy_bit(rises_a);
            prev_mdc_a = mdc_a;
            if (done_a) begin
                done_cnt_a++;
                if (q_a.size() == 0) begin
                    check_eq("a_unexpected_done", 64'(q_a.size()), 64'd1);
                end else begin
                    e_a = q_a.pop_front();
                    check_eq("a_done_cycle", 64'(cyc), 64'(e_a.done_cyc));
                    check_eq("a_bit_count", 64'(rises_a), 64'(NA));
                    check_eq("a_frame_bits", fr_a & e_a.oe, e_a.frame & e_a.oe);
                    check_eq("a_oe_pattern", oer_a, e_a.oe);
                    check_eq("a_rdata", 64'(rdata_a), 64'(e_a.rdata));
                    check_eq("a_rd_err", 64'(rd_err_a), 64'(e_a.err));
                    check_eq("a_done_pins", 64'({busy_a, mdc_a, oe_a, mdo_a}), 64'(4'b0001));
                end
                rises_a = 0; fr_a = '0; oer_a = '0; mdi_a = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rises_b = 0; fr_b = '0; prev_mdc_b = 1'b0; prev_mdo_b = 1'b1;
        end else begin
            if (mdc_b && !prev_mdc_b) begin
                check_eq("b_mdio_stable_at_rise", 64'(mdo_b), 64'(prev_mdo_b));
                check_eq("b_oe_at_rise", 64'(oe_b), 64'd1);
                fr_b = {fr_b[62:0], mdo_b};
                rises_b++;
            end
            prev_mdc_b = mdc_b;
            prev_mdo_b = mdo_b;
            if (done_b) begin
                done_cnt_b++;
                if (q_b.size() == 0) begin
                    check_eq("b_unexpected_done", 64'(q_b.size()), 64'd1);
                end else begin
                    e_b = q_b.pop_front();
                    check_eq("b_done_cycle", 64'(cyc), 64'(e_b.done_cyc));
                    check_eq("b_bit_count", 64'(rises_b), 64'(NB));
                    check_eq("b_frame_bits", fr_b, e_b.frame);
                    check_eq("b_result", 64'({rdata_b, rd_err_b}), 64'({e_b.rdata, e_b.err}));
                    check_eq("b_done_pins", 64'({busy_b, mdc_b, oe_b, mdo_b}), 64'(4'b0001));
                end
                rises_b = 0; fr_b = '0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int unsigned start;
        repeat (3) @(negedge clk);
        check_eq("a_reset_outputs", 64'({busy_a, done_a, rdata_a, rd_err_a, mdc_a, mdo_a, oe_a}),
                 64'({1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
        check_eq("b_reset_outputs", 64'({busy_b, done_b, mdc_b, mdo_b, oe_b}), 64'(5'b00010));
        rst_n = 1'b1;
        @(negedge clk);

        // Default write
        start = done_cnt_a;
        issue_a(1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, 1'b1);
        wait_done_a(start);

        // Read with responding PHY
        start = done_cnt_a;
        issue_a(1'b1, 5'h1F, 5'h02, 16'h0, 1'b1, 16'h0141, 1'b1);
        wait_done_a(start);

        // Read with silent PHY
        start = done_cnt_a;
        issue_a(1'b1, 5'h03, 5'h01, 16'h0, 1'b0, 16'h0, 1'b1);
        wait_done_a(start);

        // Requests and field changes while busy, then back-to-back accept in the done cycle
        issue_a(1'b0, 5'h02, 5'h04, 16'hA5C3, 1'b0, 16'h0, 1'b1);
        start = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_a) begin
                start = 1;
                issue_a(1'b1, 5'h07, 5'h11, 16'h0, 1'b1, 16'hBEEF, 1'b1);
                break;
            end
            req_a   = 1'b1;
            op_rd_a = 1'($urandom);
            phy_a   = 5'($urandom);
            reg_a   = 5'($urandom);
            wdata_a = 16'($urandom);
        end
        req_a = 1'b0;
        check_eq("a_first_frame_done", 64'(start), 64'd1);
        start = done_cnt_a;
        wait_done_a(start);

        // Reset during bit 40 of a read
        issue_a(1'b1, 5'h04, 5'h09, 16'h0, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 4000 && rises_a < 41; i++) @(negedge clk);
        check_eq("a_reached_bit40", 64'(rises_a), 64'd41);
        rst_n = 1'b0;
        #1;
        check_eq("a_abort_pins", 64'({oe_a, mdc_a, busy_a, done_a}), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("a_abort_regs", 64'({rdata_a, rd_err_a}), 64'd0);
        model_rdata = 16'h0;
        model_err   = 1'b0;
        rst_n = 1'b1;
        start = done_cnt_a;
        repeat (100) @(negedge clk);
        check_eq("a_no_done_after_abort", 64'(done_cnt_a), 64'(start));
        issue_a(1'b0, 5'h15, 5'h0A, 16'h0F0F, 1'b0, 16'h0, 1'b1);
        wait_done_a(start);

        // Fast instance: DivHalf=2, no preamble
        start = done_cnt_b;
        issue_b(5'h0A, 5'h15, 16'h5AA5);
        for (int i = 0; i < 400 && done_cnt_b == start; i++) @(negedge clk);
        check_eq("b_done_seen", 64'(done_cnt_b), 64'(start + 1));

        repeat (5) @(negedge clk);
        check_eq("a_queue_empty", 64'(q_a.size()), 64'd0);
        check_eq("b_queue_empty", 64'(q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
